// File: rtl/led_scan_pkg.sv
// Shared constants, display-word layout and digit-select helpers for the LED scanner.
// Words are sized for the widest legal display (8 digits); narrower builds leave the upper bits zero.
package led_scan_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam logic [7:0]  BLANK_CODE = 8'hFF;
  localparam logic [7:0]  ANODE_OFF  = 8'hFF;

  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] data;
    logic [MAX_DIGITS-1:0]   dots;
    logic [MAX_DIGITS-1:0]   blank;
  } disp_word_t;

  localparam disp_word_t SHADOW_RESET = '{data: '0, dots: '0, blank: '1};

  function automatic logic [3:0] nibble_at(input logic [4*MAX_DIGITS-1:0] data,
                                           input logic [2:0] idx);
    return 4'(data >> {idx, 2'b00});
  endfunction

  function automatic logic bit_at(input logic [MAX_DIGITS-1:0] vec, input logic [2:0] idx);
    return 1'(vec >> idx);
  endfunction

endpackage

// File: rtl/led_scan_if.sv
// Display-update handshake: the writer offers a word, the scanner signals when its pending slot is free.
interface led_scan_if #(
  parameter int DIGITS = 4
);
  logic                  wr_valid;
  logic [4*DIGITS-1:0]   wr_data;
  logic [DIGITS-1:0]     wr_dots;
  logic [DIGITS-1:0]     wr_blank;
  logic                  wr_ready;

  modport master (
    output wr_valid, wr_data, wr_dots, wr_blank,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_data, wr_dots, wr_blank,
    output wr_ready
  );
endinterface

// File: rtl/led_scan_tick.sv
// Slot prescaler: counts DIV cycles per digit slot and flags the blanking window and slot edges.
module scan_tick #(
  parameter int DIV  = 50000,
  parameter int DEAD = 16
) (
  input  logic clk,
  input  logic rst,
  output logic dead_o,
  output logic slot_start_o,
  output logic slot_end_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    slot_end_o   = (cnt_q == CW'(DIV - 1));
    slot_start_o = (cnt_q == '0);
    dead_o       = (int'(cnt_q) < DEAD);
    cnt_d        = slot_end_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_scan.sv
// Time-multiplexed common-anode LED scanner with a double-buffered display word.
// Updates are committed only at frame boundaries so a frame never mixes two words.
module led_scan
  import led_scan_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int DEAD   = 16
) (
  input  logic              clk,
  input  logic              rst,
  led_scan_if.slave         wr,
  output logic [7:0]        digit_value,
  output logic              dot_n,
  output logic [DIGITS-1:0] an_n,
  output logic              frame_start
);

  localparam int IW = 3;

  logic                dead, slot_start, slot_end;
  logic [IW-1:0]       idx_q, idx_d;
  logic                pend_q, pend_d;
  disp_word_t          pend_word_q, pend_word_d;
  disp_word_t          shadow_q, shadow_d;
  logic                last_digit, boundary, accept;
  logic                dark;

  logic [7:0]          digit_value_q, digit_value_d;
  logic                dot_n_q, dot_n_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;
  logic                frame_start_q, frame_start_d;

  scan_tick #(
    .DIV  (DIV),
    .DEAD (DEAD)
  ) u_tick (
    .clk          (clk),
    .rst          (rst),
    .dead_o       (dead),
    .slot_start_o (slot_start),
    .slot_end_o   (slot_end)
  );

  assign wr.wr_ready = !pend_q;

  always_comb begin
    last_digit  = (idx_q == IW'(DIGITS - 1));
    boundary    = slot_end && last_digit;
    accept      = wr.wr_valid && !pend_q;

    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    shadow_d    = shadow_q;

    if (slot_end) begin
      idx_d = last_digit ? '0 : idx_q + 1'b1;
    end

    // Commit uses the registered pend flag, so a write accepted on the boundary
    // cycle itself waits for the following boundary.
    if (boundary && pend_q) begin
      shadow_d = pend_word_q;
      pend_d   = 1'b0;
    end

    if (accept) begin
      pend_word_d.data  = (4*MAX_DIGITS)'(wr.wr_data);
      pend_word_d.dots  = MAX_DIGITS'(wr.wr_dots);
      pend_word_d.blank = MAX_DIGITS'(wr.wr_blank);
      pend_d            = 1'b1;
    end
  end

  always_comb begin
    dark          = dead || bit_at(shadow_q.blank, idx_q);
    digit_value_d = BLANK_CODE;
    dot_n_d       = 1'b1;
    an_n_d        = ANODE_OFF[DIGITS-1:0];
    frame_start_d = slot_start && (idx_q == '0);

    if (!dark) begin
      digit_value_d = {4'h0, nibble_at(shadow_q.data, idx_q)};
      dot_n_d       = !bit_at(shadow_q.dots, idx_q);
      an_n_d        = ~(DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q         <= '0;
      pend_q        <= 1'b0;
      pend_word_q   <= '0;
      shadow_q      <= SHADOW_RESET;
      digit_value_q <= BLANK_CODE;
      dot_n_q       <= 1'b1;
      an_n_q        <= ANODE_OFF[DIGITS-1:0];
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      pend_q        <= pend_d;
      pend_word_q   <= pend_word_d;
      shadow_q      <= shadow_d;
      digit_value_q <= digit_value_d;
      dot_n_q       <= dot_n_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign digit_value = digit_value_q;
  assign dot_n       = dot_n_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/led_scan.md
# led_scan

Time-multiplexed scanner for a multi-digit common-anode LED display. It sits directly upstream of the single-digit seven-segment decoder. It holds a display word loaded through a valid/ready handshake and cycles through the digits. For each slot it presents the selected nibble to the decoder, along with active-low digit enable and dot signals. New words take effect only at frame boundaries, so the display never tears.

## Interface
- `DIGITS`, default 4: number of digits, legal range 1..8.
- `DIV`, default 50000: clock cycles per digit slot. Must satisfy DIV ≥ DEAD+2.
- `DEAD`, default 16: blanking cycles at the start of each slot (anti-ghosting). Must be ≥ 0.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  a display update is offered.
- `wr_data`  in  4*DIGITS  nibbles; digit i = wr_data[4i+3:4i], with digit 0 rightmost.
- `wr_dots`  in  DIGITS  1 = dot lit on digit i.
- `wr_blank`  in  DIGITS  1 = digit i dark.
- `wr_ready`  out  1  the pending buffer is empty.
- `digit_value`  out  8  to the decoder: {4'h0, nibble}, or 8'hFF when dark.
- `dot_n`  out  1  active-low dot for the current slot.
- `an_n`  out  DIGITS  active-low digit enables; at most one bit is low.
- `frame_start`  out  1  one-cycle pulse on the first cycle of slot 0.

## Operation
- **State.**
  - Slot counter `cnt` runs 0..DIV-1.
  - Digit index `idx` runs 0..DIGITS-1.
  - The shadow register {data, dots, blank} drives the display.
  - A pending register has flag `pend`.
- **Handshake.**
  - wr_ready = !pend.
  - When wr_valid && wr_ready, the pending register captures the write and pend is set.
  - wr_valid held while wr_ready is low is not captured. The data stays stalled until wr_ready rises.
- **Frame boundary.** A boundary occurs when cnt == DIV-1 and idx == DIGITS-1. On that cycle:
  - cnt → 0 and idx → 0.
  - If pend is set, pending → shadow and pend clears, so wr_ready rises the next cycle.
- **Slot advance.** When cnt == DIV-1 and this is not a frame boundary, cnt → 0 and idx increments. Otherwise cnt increments.
- **Write on a boundary cycle.** A write accepted on the same cycle as a boundary (pend was 0) lands in pending and commits at the *next* boundary, not the current one.
- **Output rules** (from cnt, idx and the shadow):
  - Dead zone, cnt < DEAD: an_n all ones, digit_value 8'hFF, dot_n 1.
  - Shadow blank[idx] set: same as the dead zone for the whole slot.
  - Otherwise: an_n has only bit idx low, digit_value = {4'h0, data[idx]}, and dot_n = !dots[idx].
- **Reset** is asynchronous, mid-frame included, and drops everything at once:
  - cnt = 0, idx = 0, pend = 0.
  - Shadow data = 0, dots = 0, blank = all ones, so the display is dark until the first write commits.
  - Outputs: wr_ready = 1, an_n = all ones, digit_value = 8'hFF, dot_n = 1, frame_start = 0.

## Timing
- an_n, digit_value, dot_n and frame_start are registered from the same cycle's state. They change together one clock after the counter state that selects them, so no glitches reach the display.
- Frame period = DIGITS*DIV cycles. Lit time per digit = DIV-DEAD cycles.
- frame_start is high for exactly one cycle per frame, aligned with the first output cycle of slot 0.
- Write-to-visible latency:
  - Capture: 1 cycle after the handshake.
  - Commit: at the next boundary.
  - First lit output: DEAD+1 cycles after that boundary, on slot 0, for digits that are not blanked.
  - Worst case is DIGITS*DIV + DEAD + 2 cycles.
- wr_ready is low from the cycle after the handshake until the cycle after the commit.

## Structure
- Package `led_scan_pkg` holds:
  - BLANK_CODE = 8'hFF;
  - the anode-off constant (all ones);
  - a `disp_word_t` struct {data, dots, blank}, shared by the pending and shadow registers.
- Sub-module `scan_tick` is the prescaler. It owns cnt and emits `dead` (cnt < DEAD) and `slot_end` (cnt == DIV-1).
- `led_scan` owns idx, the handshake, the shadow and the output registers.

## Test plan
All scenarios use DIGITS=4, DIV=8, DEAD=2.
- **Reset mid-frame.** Assert rst during slot 2 → in the same cycle an_n=4'hF, digit_value=8'hFF, dot_n=1, wr_ready=1. After release, the display stays dark with no write.
- **Basic write.** Write wr_data=16'h1A2F, dots=4'b0010, blank=0 with pend=0 → wr_ready=0 the next cycle. After the boundary, the four slots show:
  - slot 0: digit_value 8'h0F, an_n 4'b1110;
  - slot 1: 8'h02, an_n 4'b1101, dot_n=0;
  - slot 2: 8'h0A, an_n 4'b1011;
  - slot 3: 8'h01, an_n 4'b0111.
  - Each slot is 2 dark cycles then 6 lit. frame_start pulses every 32 cycles.
- **Blanking.** Same write with blank=4'b0100 → during slot 2, an_n=4'hF and digit_value=8'hFF for all 8 cycles. The other slots are unchanged.
- **Back-to-back writes.** Write 16'h1111, then immediately hold wr_valid with 16'h2222 → the second write is stalled until wr_ready rises after commit, then captured. The display shows 1111 for exactly one frame, then 2222.
- **Write on a boundary cycle.** Write 16'h3333 exactly on the boundary cycle with pend=0 → the next frame still shows the old word, and 3333 appears one frame later.
